dcp_mem_responder: RTL and testbench

DCP_MEM_RESPONDER -- requirements
Module: dcp_mem_responder

---
 rtl/dcp_mem_resp_pkg.sv | 43 ++++
 rtl/dcp_req_fifo.sv | 74 +++++++
 rtl/dcp_mem_responder.sv | 114 +++++++++++
 tb/tb_dcp_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcp_mem_resp_pkg.sv
// ============================================================================
//  Module      : dcp_mem_resp_pkg
//  Description : Shared types and default constants for the DCP memory
//                responder (queue entry layout, address/line widths).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DCP_NOC_RES_DATA_SIZE
`define DCP_NOC_RES_DATA_SIZE 512
`endif
`ifndef DCP_PADDR_MASK
`define DCP_PADDR_MASK 39:0
`endif

package dcp_mem_resp_pkg;

  // Physical address and 64-byte line types derived from the NoC macros.
  typedef logic [`DCP_PADDR_MASK]             dcp_paddr_t;
  typedef logic [`DCP_NOC_RES_DATA_SIZE-1:0]  dcp_line_t;

  localparam int c_paddr_w   = $bits(dcp_paddr_t);
  localparam int c_line_w    = $bits(dcp_line_t);
  localparam int c_transid_w = 6;
  // Age only needs to reach LATENCY, which never exceeds 15.
  localparam int c_age_w     = 4;
  // Byte offset inside a 64-byte line.
  localparam int c_line_off  = 6;

  localparam int c_default_latency = 4;
  localparam int c_default_depth   = 4;
  localparam int c_default_lines   = 16;

  // One in-flight request as held in the request queue.
  typedef struct packed {
    logic [c_transid_w-1:0] transid;
    dcp_paddr_t             addr;
    logic [c_age_w-1:0]     age;
  } dcp_mem_entry_t;

endpackage : dcp_mem_resp_pkg

`default_nettype wire

// File: rtl/dcp_req_fifo.sv
// ============================================================================
//  Module      : dcp_req_fifo
//  Description : Synchronous request queue with head peek. Every entry carries
//                an age counter that counts cycles since push and saturates
//                at LATENCY, so the consumer can tell when the head is due.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcp_req_fifo
  import dcp_mem_resp_pkg::*;
#(
  parameter int DEPTH   = c_default_depth,
  parameter int LATENCY = c_default_latency
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [c_transid_w-1:0]   i_push_transid,
  input  dcp_paddr_t               i_push_addr,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output dcp_mem_entry_t           o_head
);

  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_age_w-1:0] c_age_max = c_age_w'(LATENCY);

  dcp_mem_entry_t     r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Guard against overflow/underflow so callers may assert strobes freely.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (c_ptr_w + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointers, occupancy, entry payloads and per-entry saturating age counters.
  // Stale slots keep aging too; harmless since a push restarts age at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (c_ptr_w + 1)'(w_push) - (c_ptr_w + 1)'(w_pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wr_ptr == c_ptr_w'(i))) begin
          r_mem[i].transid <= i_push_transid;
          r_mem[i].addr    <= i_push_addr;
          r_mem[i].age     <= '0;
        end else if (r_mem[i].age < c_age_max) begin
          r_mem[i].age <= r_mem[i].age + 1'b1;
        end
      end
    end
  end

endmodule : dcp_req_fifo

`default_nettype wire

// File: rtl/dcp_mem_responder.sv
// ============================================================================
//  Module      : dcp_mem_responder
//  Description : Fixed-latency, in-order memory model for the DCP accelerator
//                port. Requests are queued, aged, and answered with a line
//                from a preloadable backing store LATENCY cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DCP_NOC_RES_DATA_SIZE
`define DCP_NOC_RES_DATA_SIZE 512
`endif
`ifndef DCP_PADDR_MASK
`define DCP_PADDR_MASK 39:0
`endif

module dcp_mem_responder
  import dcp_mem_resp_pkg::*;
#(
  parameter int LATENCY = c_default_latency,
  parameter int DEPTH   = c_default_depth,
  parameter int LINES   = c_default_lines
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mem_req_val,
  output logic                              mem_req_rdy,
  input  logic [5:0]                        mem_req_transid,
  input  logic [`DCP_PADDR_MASK]            mem_req_addr,
  output logic                              mem_resp_val,
  output logic [5:0]                        mem_resp_transid,
  output logic [`DCP_NOC_RES_DATA_SIZE-1:0] mem_resp_data,
  input  logic                              resp_hold,
  input  logic                              ld_val,
  input  logic [$clog2(LINES)-1:0]          ld_idx,
  input  logic [`DCP_NOC_RES_DATA_SIZE-1:0] ld_data,
  output logic [$clog2(DEPTH):0]            outstanding
);

  localparam int                 c_idx_w     = $clog2(LINES);
  localparam logic [c_age_w-1:0] c_issue_age = c_age_w'(LATENCY - 1);

  dcp_line_t            r_store [LINES];
  logic                 r_live;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_aged;
  logic                 w_full;
  logic                 w_empty;
  logic [c_idx_w-1:0]   w_head_idx;
  dcp_mem_entry_t       w_head;
  logic                 w_unused_addr;

  dcp_req_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_req_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_push         (w_accept),
    .i_push_transid (mem_req_transid),
    .i_push_addr    (mem_req_addr),
    .i_pop          (w_issue),
    .o_full         (w_full),
    .o_empty        (w_empty),
    .o_count        (outstanding),
    .o_head         (w_head)
  );

  // Ready comes from occupancy only: a pop in the same cycle does not free a
  // slot early, and r_live keeps ready low until the first edge after reset.
  assign mem_req_rdy = r_live & ~w_full;
  assign w_accept    = mem_req_val & mem_req_rdy;

  // With LATENCY=1 the head is due immediately; skip the degenerate compare.
  if (LATENCY == 1) begin : g_lat_one
    assign w_aged = 1'b1;
  end else begin : g_lat_multi
    assign w_aged = (w_head.age >= c_issue_age);
  end

  assign w_issue    = ~w_empty & w_aged & ~resp_hold;
  assign w_head_idx = w_head.addr[c_line_off +: c_idx_w];
  // Only the line-index bits of the stored address select data.
  assign w_unused_addr = ^w_head.addr;

  // Ready enable and registered response; data/ID hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live           <= 1'b0;
      mem_resp_val     <= 1'b0;
      mem_resp_transid <= '0;
      mem_resp_data    <= '0;
    end else begin
      r_live       <= 1'b1;
      mem_resp_val <= w_issue;
      if (w_issue) begin
        mem_resp_transid <= w_head.transid;
        mem_resp_data    <= r_store[w_head_idx];
      end
    end
  end

  // Backing-store preload; not reset so contents survive a mid-run reset.
  // A same-cycle issue to this index reads the pre-write value.
  always_ff @(posedge clk) begin
    if (ld_val) begin
      r_store[ld_idx] <= ld_data;
    end
  end

endmodule : dcp_mem_responder

`default_nettype wire

// File: tb/tb_dcp_mem_responder.sv
// ============================================================================
//  Module      : tb_dcp_mem_responder
//  Description : Directed self-checking bench for dcp_mem_responder (default
//                parameters plus a LATENCY=1 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcp_mem_responder;
  import dcp_mem_resp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_req_val;
  logic        l1_req_val;
  logic [5:0]  mem_req_transid;
  dcp_paddr_t  mem_req_addr;
  logic        resp_hold;
  logic        ld_val;
  logic [3:0]  ld_idx;
  dcp_line_t   ld_data;

  logic        mem_req_rdy;
  logic        mem_resp_val;
  logic [5:0]  mem_resp_transid;
  dcp_line_t   mem_resp_data;
  logic [2:0]  outstanding;

  logic        l1_req_rdy;
  logic        l1_resp_val;
  logic [5:0]  l1_resp_transid;
  dcp_line_t   l1_resp_data;
  logic [2:0]  l1_outstanding;

  int n_checks = 0;
  int n_pass   = 0;

  dcp_mem_responder u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_req_val      (mem_req_val),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_transid  (mem_req_transid),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_transid (mem_resp_transid),
    .mem_resp_data    (mem_resp_data),
    .resp_hold        (resp_hold),
    .ld_val           (ld_val),
    .ld_idx           (ld_idx),
    .ld_data          (ld_data),
    .outstanding      (outstanding)
  );

  dcp_mem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_req_val      (l1_req_val),
    .mem_req_rdy      (l1_req_rdy),
    .mem_req_transid  (mem_req_transid),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_val     (l1_resp_val),
    .mem_resp_transid (l1_resp_transid),
    .mem_resp_data    (l1_resp_data),
    .resp_hold        (resp_hold),
    .ld_val           (ld_val),
    .ld_idx           (ld_idx),
    .ld_data          (ld_data),
    .outstanding      (l1_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input dcp_line_t got, input dcp_line_t exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input dcp_line_t d);
    ld_val  = 1'b1;
    ld_idx  = 4'(idx);
    ld_data = d;
    tick();
    ld_val  = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [5:0] id, input dcp_line_t d);
    check({tag, "_val"}, dcp_line_t'(mem_resp_val), 1);
    check({tag, "_id"},  dcp_line_t'(mem_resp_transid), dcp_line_t'(id));
    check({tag, "_data"}, mem_resp_data, d);
  endtask

  // Single request with no contention: silent for LATENCY cycles, then answer.
  task automatic req_check(input string tag, input logic [5:0] id,
                           input dcp_paddr_t addr, input dcp_line_t d);
    mem_req_val     = 1'b1;
    mem_req_transid = id;
    mem_req_addr    = addr;
    tick();
    mem_req_val = 1'b0;
    check({tag, "_out1"}, dcp_line_t'(outstanding), 1);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_quiet"}, dcp_line_t'(mem_resp_val), 0);
      tick();
    end
    expect_resp(tag, id, d);
  endtask

  function automatic dcp_line_t line_pat(input int i);
    logic [7:0] b;
    b = (i == 3) ? 8'hA5 : 8'(i * 17);
    return {64{b}};
  endfunction

  initial begin
    dcp_paddr_t addr_b [5];
    logic       any_val;
    addr_b = '{40'h7F, 40'hF0_0000_0080, 40'hC0, 40'h100, 40'h140};

    rst_n = 1'b0; mem_req_val = 1'b0; l1_req_val = 1'b0; mem_req_transid = '0;
    mem_req_addr = '0; resp_hold = 1'b0; ld_val = 1'b0; ld_idx = '0; ld_data = '0;
    repeat (3) tick();

    // Reset values
    check("rst_val", dcp_line_t'(mem_resp_val), 0);
    check("rst_id", dcp_line_t'(mem_resp_transid), 0);
    check("rst_data", mem_resp_data, 0);
    check("rst_out", dcp_line_t'(outstanding), 0);
    check("rst_rdy", dcp_line_t'(mem_req_rdy), 0);
    rst_n = 1'b1;
    #1;
    check("rdy_pre_edge", dcp_line_t'(mem_req_rdy), 0);
    tick();
    check("rdy_up", dcp_line_t'(mem_req_rdy), 1);

    for (int i = 0; i < 16; i++) load(i, line_pat(i));

    // Basic latency: id 7 to line 3
    req_check("lat4", 6'd7, 40'hC0, {64{8'hA5}});
    tick();
    check("hold_val", dcp_line_t'(mem_resp_val), 0);
    check("hold_id", dcp_line_t'(mem_resp_transid), 7);
    check("hold_data", mem_resp_data, {64{8'hA5}});
    check("lat4_out0", dcp_line_t'(outstanding), 0);

    // Five back-to-back requests into a 4-deep queue
    for (int i = 0; i < 4; i++) begin
      mem_req_val = 1'b1; mem_req_transid = 6'(i + 1); mem_req_addr = addr_b[i];
      tick();
      check("b2b_out", dcp_line_t'(outstanding), dcp_line_t'(i + 1));
    end
    check("full_rdy", dcp_line_t'(mem_req_rdy), 0);
    mem_req_transid = 6'd5; mem_req_addr = addr_b[4];
    tick();
    check("full_no_bypass", dcp_line_t'(outstanding), 3);
    check("rdy_after_pop", dcp_line_t'(mem_req_rdy), 1);
    expect_resp("b2b1", 6'd1, {64{8'h11}});
    tick();
    mem_req_val = 1'b0;
    check("b2b_acc5_out", dcp_line_t'(outstanding), 3);
    expect_resp("b2b2", 6'd2, {64{8'h22}});
    tick(); expect_resp("b2b3", 6'd3, {64{8'hA5}});
    tick(); expect_resp("b2b4", 6'd4, {64{8'h44}});
    tick(); check("b2b_gap", dcp_line_t'(mem_resp_val), 0);
    tick(); expect_resp("b2b5", 6'd5, {64{8'h55}});
    check("b2b_out0", dcp_line_t'(outstanding), 0);

    // Congestion hold over three aged requests
    resp_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_req_val = (i < 3);
      mem_req_transid = 6'(10 + i);
      mem_req_addr = 40'(64 * (4 + i));
      tick();
      check("hold_quiet", dcp_line_t'(mem_resp_val), 0);
    end
    check("hold_out", dcp_line_t'(outstanding), 3);
    resp_hold = 1'b0;
    tick(); expect_resp("rel1", 6'd10, {64{8'h44}});
    tick(); expect_resp("rel2", 6'd11, {64{8'h55}});
    tick(); expect_resp("rel3", 6'd12, {64{8'h66}});
    tick(); check("rel_end", dcp_line_t'(mem_resp_val), 0);

    // Preload collides with the issue of a line-2 request
    mem_req_val = 1'b1; mem_req_transid = 6'd20; mem_req_addr = 40'h80;
    tick();
    mem_req_val = 1'b0;
    repeat (3) tick();
    ld_val = 1'b1; ld_idx = 4'd2; ld_data = {64{8'hE2}};
    tick();
    ld_val = 1'b0;
    expect_resp("coll_old", 6'd20, {64{8'h22}});
    req_check("coll_new", 6'd21, 40'h80, {64{8'hE2}});

    // Simultaneous accept and issue at outstanding=2
    mem_req_val = 1'b1; mem_req_transid = 6'd30; mem_req_addr = 40'h40;
    tick();
    mem_req_transid = 6'd31; mem_req_addr = 40'h100;
    tick();
    mem_req_val = 1'b0;
    repeat (2) tick();
    check("sim_out_pre", dcp_line_t'(outstanding), 2);
    mem_req_val = 1'b1; mem_req_transid = 6'd32; mem_req_addr = 40'h140;
    tick();
    mem_req_val = 1'b0;
    check("sim_out_keep", dcp_line_t'(outstanding), 2);
    expect_resp("sim1", 6'd30, {64{8'h11}});
    tick(); expect_resp("sim2", 6'd31, {64{8'h44}});
    check("sim_out_dec", dcp_line_t'(outstanding), 1);
    repeat (3) tick();
    expect_resp("sim3", 6'd32, {64{8'h55}});
    check("sim_out0", dcp_line_t'(outstanding), 0);

    // LATENCY=1 instance
    l1_req_val = 1'b1; mem_req_transid = 6'd40; mem_req_addr = 40'h140;
    tick();
    l1_req_val = 1'b0;
    check("l1_out", dcp_line_t'(l1_outstanding), 1);
    check("l1_quiet", dcp_line_t'(l1_resp_val), 0);
    tick();
    check("l1_val", dcp_line_t'(l1_resp_val), 1);
    check("l1_id", dcp_line_t'(l1_resp_transid), 40);
    check("l1_data", l1_resp_data, {64{8'h55}});

    // Reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      mem_req_val = 1'b1; mem_req_transid = 6'(50 + i); mem_req_addr = 40'hC0;
      tick();
    end
    mem_req_val = 1'b0;
    check("mid_out3", dcp_line_t'(outstanding), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", dcp_line_t'(outstanding), 0);
    check("mid_rst_rdy", dcp_line_t'(mem_req_rdy), 0);
    check("mid_rst_val", dcp_line_t'(mem_resp_val), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    any_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_resp_val) any_val = 1'b1;
    end
    check("mid_no_resp", dcp_line_t'(any_val), 0);
    check("mid_rdy", dcp_line_t'(mem_req_rdy), 1);
    req_check("post_rst", 6'd60, 40'hC0, {64{8'hA5}});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dcp_mem_responder

`default_nettype wire
